// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   arb_state_e  : arbiter FSM encoding (IDLE / GNT0 / GNT1 / TURN)
//   ARB_ADDR_W   : default SRAM address width (512 words)
//   ARB_DATA_W   : default SRAM data width
//   wdog_cnt_w() : width of the watchdog counter for a given timeout
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10,
    ARB_TURN = 2'b11
  } arb_state_e;

  localparam int ARB_ADDR_W      = 9;
  localparam int ARB_DATA_W      = 8;
  localparam int ARB_WDOG_CYCLES = 256;

  // Counter only has to reach WDOG_CYCLES-1; keep at least one bit.
  function automatic int wdog_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM arbiter, both ports bundled.
//   REQ0/REQ1, CEN0/CEN1, WEN0/WEN1, A0/A1, D0/D1 : requester -> arbiter
//   GNT0/GNT1, RVLD0/RVLD1, Q                      : arbiter -> requesters
// Modports: master = requesters (loader + SPI readout), slave = arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) ();

  logic                  REQ0, REQ1;
  logic                  GNT0, GNT1;
  logic                  CEN0, CEN1;
  logic                  WEN0, WEN1;
  logic [ADDR_WIDTH-1:0] A0, A1;
  logic [DATA_WIDTH-1:0] D0, D1;
  logic [DATA_WIDTH-1:0] Q;
  logic                  RVLD0, RVLD1;

  modport master (
    output REQ0, REQ1, CEN0, CEN1, WEN0, WEN1, A0, A1, D0, D1,
    input  GNT0, GNT1, Q, RVLD0, RVLD1
  );

  modport slave (
    input  REQ0, REQ1, CEN0, CEN1, WEN0, WEN1, A0, A1, D0, D1,
    output GNT0, GNT1, Q, RVLD0, RVLD1
  );

endinterface

// File: rtl/sram_arb_wdog.sv
// Grant-hold watchdog for the SRAM arbiter (built only with
// SRAM_ARB_WATCHDOG_EN).
//   clk, rst_n : clock, async active-low reset
//   run        : current owner holds the grant while the other port waits
//   err_clr    : clears the sticky error flag at a clock edge
//   timeout    : combinational, owner has held WDOG_CYCLES waiting cycles
//   err        : sticky timeout flag
module sram_arb_wdog
  import sram_arb_pkg::*;
#(
  parameter int WDOG_CYCLES = ARB_WDOG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic err_clr,
  output logic timeout,
  output logic err
);

  localparam int              CNT_W    = wdog_cnt_w(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout = run && (cnt_q == CNT_LAST);
  assign err     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    // Counter restarts whenever nobody is waiting or the owner is preempted.
    if (!run || timeout) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
    // A fresh timeout wins over a clear in the same cycle so it is never lost.
    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the shared 512x8 single-port SRAM.
// Port 0 = serial loader, port 1 = pseudo-SPI readout.
//   CLK, RST_N             : clock, async active-low reset
//   bus (slave)            : REQ/GNT handshake, CEN/WEN/A/D per port,
//                            broadcast Q, per-port RVLD strobe
//   SRAM_CEN/WEN/A/D/Q     : macro pins
//   ERR_CLR, ERR           : watchdog error clear / sticky flag
// Round-robin between the ports with one dead TURN cycle between owners.
// Optional macro SRAM_ARB_WATCHDOG_EN adds a grant-hold watchdog; without
// it ERR is tied low and grants are held for as long as REQ stays high.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ARB_ADDR_W,
  parameter int DATA_WIDTH  = ARB_DATA_W,
  parameter int WDOG_CYCLES = ARB_WDOG_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  sram_port_arbiter_if.slave    bus,
  output logic                  SRAM_CEN,
  output logic                  SRAM_WEN,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q,
  input  logic                  ERR_CLR,
  output logic                  ERR
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // index of the port served last
  logic [1:0] rvld_q, rvld_d;
  logic       wdog_to;

`ifdef SRAM_ARB_WATCHDOG_EN
  logic wdog_run;
  assign wdog_run = ((state_q == ARB_GNT0) && bus.REQ1) ||
                    ((state_q == ARB_GNT1) && bus.REQ0);

  sram_arb_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (CLK),
    .rst_n   (RST_N),
    .run     (wdog_run),
    .err_clr (ERR_CLR),
    .timeout (wdog_to),
    .err     (ERR)
  );
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign wdog_to        = 1'b0;
  assign ERR            = 1'b0;
`endif

  // Next-state / priority pointer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.REQ0 && bus.REQ1) state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        else if (bus.REQ0)        state_d = ARB_GNT0;
        else if (bus.REQ1)        state_d = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (!bus.REQ0 || wdog_to) begin
          state_d = ARB_TURN;
          last_d  = 1'b0;
        end
      end
      ARB_GNT1: begin
        if (!bus.REQ1 || wdog_to) begin
          state_d = ARB_TURN;
          last_d  = 1'b1;
        end
      end
      ARB_TURN: begin
        // The port that did not just own the SRAM goes first.
        if (last_q) begin
          if (bus.REQ0)      state_d = ARB_GNT0;
          else if (bus.REQ1) state_d = ARB_GNT1;
          else               state_d = ARB_IDLE;
        end else begin
          if (bus.REQ1)      state_d = ARB_GNT1;
          else if (bus.REQ0) state_d = ARB_GNT0;
          else               state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Macro drive straight from the state: a port's pins only reach the SRAM
  // while it holds the grant, so a non-owner's CEN can never fire.
  always_comb begin
    SRAM_CEN = 1'b1;
    SRAM_WEN = 1'b1;
    SRAM_A   = '0;
    SRAM_D   = '0;
    unique case (state_q)
      ARB_GNT0: begin
        SRAM_CEN = bus.CEN0;
        SRAM_WEN = bus.WEN0;
        SRAM_A   = bus.A0;
        SRAM_D   = bus.D0;
      end
      ARB_GNT1: begin
        SRAM_CEN = bus.CEN1;
        SRAM_WEN = bus.WEN1;
        SRAM_A   = bus.A1;
        SRAM_D   = bus.D1;
      end
      default: ;
    endcase
  end

  // Read strobe follows the access by one edge, tagged with the owner at
  // the time of the access (so it may land in TURN).
  always_comb begin
    rvld_d    = '0;
    rvld_d[0] = (state_q == ARB_GNT0) && !SRAM_CEN && SRAM_WEN;
    rvld_d[1] = (state_q == ARB_GNT1) && !SRAM_CEN && SRAM_WEN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      rvld_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rvld_q  <= rvld_d;
    end
  end

  assign bus.GNT0  = (state_q == ARB_GNT0);
  assign bus.GNT1  = (state_q == ARB_GNT1);
  assign bus.RVLD0 = rvld_q[0];
  assign bus.RVLD1 = rvld_q[1];
  assign bus.Q     = SRAM_Q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM macro, shadow memory for
// expected data, and a read scoreboard checked on the falling clock edge.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int WD = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          SRAM_CEN, SRAM_WEN;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] sram_q;
  logic          ERR_CLR, ERR;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_CYCLES(WD)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus),
    .SRAM_CEN (SRAM_CEN),
    .SRAM_WEN (SRAM_WEN),
    .SRAM_A   (SRAM_A),
    .SRAM_D   (SRAM_D),
    .SRAM_Q   (sram_q),
    .ERR_CLR  (ERR_CLR),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // Macro model: synchronous write / registered read.
  logic [DW-1:0] mem [0:511];
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_WEN) mem[SRAM_A] <= SRAM_D;
      else           sram_q      <= mem[SRAM_A];
    end
  end

  logic [DW-1:0] shadow [0:511];
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push_rd(input logic port, input logic [AW-1:0] addr);
    exp_t e;
    e.due  = cyc + 1;
    e.port = port;
    e.data = shadow[addr];
    sb.push_back(e);
  endtask

  // Scoreboard: every expected read must strobe on its due cycle on the
  // right port with the right data; any other strobe is spurious.
  always @(negedge CLK) begin : sb_mon
    exp_t e;
    if (RST_N) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("sb_rvld", {30'd0, bus.RVLD1, bus.RVLD0}, e.port ? 32'd2 : 32'd1);
        chk("sb_data", {24'd0, bus.Q}, {24'd0, e.data});
      end else if (bus.RVLD0 || bus.RVLD1) begin
        chk("sb_spurious", {30'd0, bus.RVLD1, bus.RVLD0}, 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; ERR_CLR = 1'b0;
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    bus.CEN0 = 1'b1; bus.WEN0 = 1'b1; bus.A0 = '0; bus.D0 = '0;
    bus.CEN1 = 1'b1; bus.WEN1 = 1'b1; bus.A1 = '0; bus.D1 = '0;

    // Reset with both ports requesting.
    repeat (3) tick;
    chk("rst_gnt",  {bus.GNT1, bus.GNT0}, 0);
    chk("rst_cen",  SRAM_CEN, 1);
    chk("rst_wen",  SRAM_WEN, 1);
    chk("rst_a",    SRAM_A, 0);
    chk("rst_d",    SRAM_D, 0);
    chk("rst_rvld", {bus.RVLD1, bus.RVLD0}, 0);
    chk("rst_err",  ERR, 0);
    RST_N = 1'b1;
    tick;
    chk("first_gnt", {bus.GNT1, bus.GNT0}, 2'b01);

    // Round-robin with turnaround.
    bus.REQ0 = 1'b0;
    tick;
    chk("turn_gnt", {bus.GNT1, bus.GNT0}, 0);
    chk("turn_cen", SRAM_CEN, 1);
    tick;
    chk("rr_gnt1", {bus.GNT1, bus.GNT0}, 2'b10);
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b0;
    tick;
    chk("turn2_gnt", {bus.GNT1, bus.GNT0}, 0);
    tick;
    chk("rr_gnt0", {bus.GNT1, bus.GNT0}, 2'b01);

    // Port 0 writes AB@020 and drops REQ in the same cycle.
    bus.CEN0 = 1'b0; bus.WEN0 = 1'b0; bus.A0 = 9'h020; bus.D0 = 8'hAB;
    bus.REQ0 = 1'b0;
    #1;
    chk("wr_wen", SRAM_WEN, 0);
    chk("wr_a",   SRAM_A, 9'h020);
    chk("wr_d",   SRAM_D, 8'hAB);
    shadow[9'h020] = 8'hAB;
    tick;
    bus.CEN0 = 1'b1; bus.WEN0 = 1'b1;
    bus.REQ1 = 1'b1;
    chk("ld_turn_cen", SRAM_CEN, 1);
    tick;
    chk("ld_gnt1", {bus.GNT1, bus.GNT0}, 2'b10);

    // Port 1 reads it back.
    bus.CEN1 = 1'b0; bus.WEN1 = 1'b1; bus.A1 = 9'h020;
    push_rd(1'b1, 9'h020);
    tick;
    chk("rd_rvld", {bus.RVLD1, bus.RVLD0}, 2'b10);
    chk("rd_q",    bus.Q, 8'hAB);
    // Final read together with the release: strobe lands in TURN.
    push_rd(1'b1, 9'h020);
    bus.REQ1 = 1'b0;
    tick;
    chk("turn_rvld1", bus.RVLD1, 1);
    chk("turn_gnt3",  {bus.GNT1, bus.GNT0}, 0);
    bus.CEN1 = 1'b1;

    // Gating: port 1 drives a write while port 0 owns the SRAM.
    bus.REQ0 = 1'b1;
    tick;
    chk("gt_gnt0", {bus.GNT1, bus.GNT0}, 2'b01);
    chk("gt_norvld", {bus.RVLD1, bus.RVLD0}, 0);
    bus.CEN0 = 1'b0; bus.WEN0 = 1'b0; bus.A0 = 9'h040; bus.D0 = 8'h11;
    shadow[9'h040] = 8'h11;
    tick;
    bus.A0 = 9'h030; bus.D0 = 8'h55;
    bus.CEN1 = 1'b0; bus.WEN1 = 1'b0; bus.A1 = 9'h040; bus.D1 = 8'hEE;
    shadow[9'h030] = 8'h55;
    #1;
    chk("gt_a", SRAM_A, 9'h030);
    chk("gt_d", SRAM_D, 8'h55);
    tick;
    bus.WEN0 = 1'b1;
    #1;
    chk("gt_wen", SRAM_WEN, 1);
    push_rd(1'b0, 9'h030);
    tick;
    bus.A0 = 9'h040;
    bus.CEN1 = 1'b1; bus.WEN1 = 1'b1;
    push_rd(1'b0, 9'h040);
    tick;
    chk("gt_q040", bus.Q, 8'h11);
    bus.CEN0 = 1'b1;
    bus.REQ0 = 1'b0;
    tick;
    tick;
    chk("idle_gnt", {bus.GNT1, bus.GNT0}, 0);

    // Long hold by port 0 while port 1 waits.
    bus.REQ0 = 1'b1;
    tick;
    bus.REQ1 = 1'b1;
`ifdef SRAM_ARB_WATCHDOG_EN
    for (int i = 0; i < WD - 1; i++) begin
      tick;
      chk("wd_hold", bus.GNT0, 1);
    end
    chk("wd_err_pre", ERR, 0);
    tick;
    chk("wd_drop", {bus.GNT1, bus.GNT0}, 0);
    chk("wd_err",  ERR, 1);
    chk("wd_cen",  SRAM_CEN, 1);
    tick;
    chk("wd_gnt1", {bus.GNT1, bus.GNT0}, 2'b10);
    chk("wd_err_sticky", ERR, 1);
    ERR_CLR = 1'b1; bus.REQ1 = 1'b0;
    tick;
    ERR_CLR = 1'b0;
    chk("wd_clr", ERR, 0);
    tick;
    chk("wd_regrant", {bus.GNT1, bus.GNT0}, 2'b01);
    bus.REQ0 = 1'b0;
    tick;
    tick;
`else
    for (int i = 0; i < 3 * WD; i++) begin
      tick;
      chk("nowd_hold", bus.GNT0, 1);
    end
    ERR_CLR = 1'b1;
    tick;
    ERR_CLR = 1'b0;
    chk("nowd_err", ERR, 0);
    bus.REQ0 = 1'b0;
    tick;
    tick;
    chk("nowd_gnt1", {bus.GNT1, bus.GNT0}, 2'b10);
    bus.REQ1 = 1'b0;
    tick;
    tick;
`endif
    chk("idle2_gnt", {bus.GNT1, bus.GNT0}, 0);

    // Async reset in the middle of a port 1 read burst.
    bus.REQ1 = 1'b1;
    tick;
    bus.CEN1 = 1'b0; bus.WEN1 = 1'b1; bus.A1 = 9'h020;
    push_rd(1'b1, 9'h020);
    tick;
    bus.A1 = 9'h030;
    push_rd(1'b1, 9'h030);
    tick;
    bus.A1 = 9'h020;        // in flight when reset hits, no strobe expected
    tick;
    chk("pre_rst_rvld1", bus.RVLD1, 1);
    RST_N = 1'b0;
    #1;
    chk("arst_rvld1", bus.RVLD1, 0);
    chk("arst_gnt1",  bus.GNT1, 0);
    chk("arst_cen",   SRAM_CEN, 1);
    chk("arst_a",     SRAM_A, 0);
    bus.CEN1 = 1'b1; bus.REQ1 = 1'b0;
    tick;
    RST_N = 1'b1;
    tick;
    tick;
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
